seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_decode.sv | 36 +++
 rtl/seg_scan_ctrl.sv | 116 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// seg_pkg : segment patterns, blanking constants and FSM state type
// Revision : 1.0
// ============================================================================
package seg_pkg;

  // Active-low g..a patterns, dp excluded
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEL_OFF = 8'hFF;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seg_decode.sv
`default_nettype none
// ============================================================================
// seg_decode : hex nibble to active-low 7-segment pattern (g..a)
// Revision   : 1.0
// ============================================================================
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_8;
    case (nibble_i)
      4'h0:    seg_n_o = SEG_0;
      4'h1:    seg_n_o = SEG_1;
      4'h2:    seg_n_o = SEG_2;
      4'h3:    seg_n_o = SEG_3;
      4'h4:    seg_n_o = SEG_4;
      4'h5:    seg_n_o = SEG_5;
      4'h6:    seg_n_o = SEG_6;
      4'h7:    seg_n_o = SEG_7;
      4'h8:    seg_n_o = SEG_8;
      4'h9:    seg_n_o = SEG_9;
      4'hA:    seg_n_o = SEG_A;
      4'hB:    seg_n_o = SEG_B;
      4'hC:    seg_n_o = SEG_C;
      4'hD:    seg_n_o = SEG_D;
      4'hE:    seg_n_o = SEG_E;
      default: seg_n_o = SEG_F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// seg_scan_ctrl : 8-digit multiplexed 7-segment scanner with blanking
// Revision      : 1.0
// ============================================================================
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [7:0] digit_en,
  output logic [7:0] sel,
  output logic [7:0] seg,
  output logic       frame_done
);

  localparam int unsigned      CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_e           state_q, state_d;
  logic [2:0]       dig_q, dig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_q, frame_d;
  logic [4:0]       dbuf_q [8];
  logic [7:0]       sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;
  logic [4:0]       cur_entry;
  logic [6:0]       cur_pat;
  logic             lit;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) dbuf_q[i] <= '0;
    end else if (wr_en) begin
      dbuf_q[wr_addr] <= {wr_dp, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      dig_q   <= '0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      sel_q   <= SEL_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q + CNT_W'(1);
    frame_d = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          dig_d   = dig_q + 3'd1;
          frame_d = (dig_q == 3'd7);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // sel and seg come from the same dig_q on the same edge, so they never disagree
  assign cur_entry = dbuf_q[dig_q];

  seg_decode u_seg_decode (
    .nibble_i (cur_entry[3:0]),
    .seg_n_o  (cur_pat)
  );

  always_comb begin
    lit   = (state_q == ST_SHOW) && digit_en[dig_q];
    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    if (lit) begin
      sel_d = ~(8'd1 << dig_q);
      seg_d = {~cur_entry[4], cur_pat};
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_ctrl : randomized scoreboard bench for seg_scan_ctrl
// Revision         : 1.0
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int P  = SD + BC;
  localparam int FRAME = 8 * P;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] seg;
    logic       fd;
    logic       rs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic [7:0] digit_en = 8'hFF;
  logic [7:0] sel;
  logic [7:0] seg;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  exp_t exp_q [$];
  logic [4:0] mbuf [8];
  int  n_edges = 0;
  bit  started = 1'b0;
  int  gap = -1;
  int  cyc = 0;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .digit_en   (digit_en),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: the scan is a fixed timeline measured from the last reset edge
  always @(posedge clk) begin
    exp_t e;
    int j, pos, slot;
    logic [7:0] pat;
    cyc++;
    e = '{sel: 8'hFF, seg: 8'hFF, fd: 1'b0, rs: 1'b0};
    if (rst) begin
      started = 1'b1;
      n_edges = 0;
      for (int i = 0; i < 8; i++) mbuf[i] = '0;
      e.rs = 1'b1;
    end else if (started) begin
      n_edges++;
      j    = n_edges - 1;
      pos  = j % P;
      slot = (j / P) % 8;
      e.fd = ((j % FRAME) == FRAME - 1);
      if (pos >= BC && digit_en[slot]) begin
        pat   = SEG_TAB[mbuf[slot][3:0]];
        e.sel = ~(8'h01 << slot);
        e.seg = {~mbuf[slot][4], pat[6:0]};
      end
      if (wr_en) mbuf[wr_addr] = {wr_dp, wr_data};
    end
    if (started) exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cyc=%0d: no expected entry for DUT output", cyc);
      end else begin
        e = exp_q.pop_front();
        if (sel !== e.sel || seg !== e.seg || frame_done !== e.fd) begin
          errors++;
          $display("FAIL out cyc=%0d: got sel=%h seg=%h fd=%b, need sel=%h seg=%h fd=%b",
                   cyc, sel, seg, frame_done, e.sel, e.seg, e.fd);
        end
        checks++;
        if ($countones(~sel) > 1) begin
          errors++;
          $display("FAIL sel_onehot cyc=%0d: got sel=%h, need at most one low bit", cyc, sel);
        end
        if (e.rs) gap = -1;
        else if (gap >= 0) gap++;
        if (frame_done === 1'b1) begin
          if (gap >= 0) begin
            checks++;
            if (gap != FRAME) begin
              errors++;
              $display("FAIL frame_period cyc=%0d: got %0d cycles, need %0d", cyc, gap, FRAME);
            end
          end
          gap = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b0;
      wr_addr = 3'($urandom);
      wr_data = 4'($urandom);
      wr_dp   = 1'($urandom);
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [3:0] d, input logic dp);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = dp;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Free-running scan with an empty buffer; junk on wr_addr/wr_data is ignored
    idle(90);

    // Digit 3 = A with decimal point
    write(3'd3, 4'hA, 1'b1);
    idle(50);

    // Rewrite digit 2 while it is being shown
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (sel == 8'hFB) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_slot2: got no sel=FB within 60 cycles, need one");
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h5; wr_dp = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    idle(45);

    // Digit 2 disabled
    digit_en = 8'b1111_1011;
    idle(90);
    digit_en = 8'hFF;

    // Reset in the middle of digit 5's slot
    do_reset(2);
    repeat (27) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(45);

    // All 16 nibbles across two frames
    for (int i = 0; i < 16; i++) begin
      write(3'(i % 8), 4'(i), 1'($urandom));
      idle(3);
    end
    idle(90);

    // Randomized writes, enable changes and occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom);
      wr_data = 4'($urandom);
      wr_dp   = 1'($urandom);
      if ($urandom_range(0, 19) == 0) digit_en = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
